// File: rtl/approx_mul_pkg.sv
// Shared widths, defaults and the S1 payload type for the approximate multiplier arbiter.
// APPROX_MUL_EXACT_EN adds a per-request exact-product select carried in the payload.
package approx_mul_pkg;

  localparam int OPW          = 8;
  localparam int PRW          = 16;
  localparam int NREQ_DEFAULT = 4;
  localparam int ID_MAXW      = 3;

  // id is sized for the largest supported requester count; the top narrows it to IDW.
  typedef struct packed {
`ifdef APPROX_MUL_EXACT_EN
    logic               exact;
`endif
    logic [ID_MAXW-1:0] id;
    logic [OPW-1:0]     y;
    logic [OPW-1:0]     x;
  } s1_payload_t;

endpackage

// File: rtl/approx_mul8_core.sv
// Combinational 8x8 multiplier: truncated partial-product approximation, or exact when selected.
module approx_mul8_core
  import approx_mul_pkg::*;
(
  input  logic [OPW-1:0] x,
  input  logic [OPW-1:0] y,
  input  logic           exact,
  output logic [PRW-1:0] z
);

  logic [OPW-1:0]  p1, p2, p3;
  logic [11:0]     hi;
  logic [1:0]      c8, c9, c10;
  logic [PRW-1:0]  approx_z;
  logic [PRW-1:0]  exact_z;

  // Low partial products contribute only their top bits as carries into z[10:8].
  always_comb begin
    p1       = y & {OPW{x[1]}};
    p2       = y & {OPW{x[2]}};
    p3       = y & {OPW{x[3]}};
    hi       = {4'b0, y} * {8'b0, x[7:4]};
    c8       = {1'b0, p1[7]} + {1'b0, p2[5] | p3[4]};
    c9       = {1'b0, p2[6] | p3[5]} + {1'b0, p2[7] ^ p3[6]};
    c10      = {1'b0, p2[7] & p3[6]} + {1'b0, p3[7]};
    approx_z = {hi, 4'b0}
             + {6'b0, c8, 8'b0}
             + {5'b0, c9, 9'b0}
             + {4'b0, c10, 10'b0};
    exact_z  = {8'b0, x} * {8'b0, y};
    z        = exact ? exact_z : approx_z;
  end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage shared multiplier pipeline (S1 operands, S2 result).
// Define APPROX_MUL_EXACT_EN to add the req_exact input selecting exact products.
module approx_mul_arbiter
  import approx_mul_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_x,
  input  logic [NREQ*OPW-1:0] req_y,
`ifdef APPROX_MUL_EXACT_EN
  input  logic [NREQ-1:0]     req_exact,
`endif
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PRW-1:0]      res_z,
  output logic [IDW-1:0]      res_id
);

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] gidx;
  logic           found;
  int unsigned    idx;

  logic           s1_valid;
  s1_payload_t    s1_q;
  s1_payload_t    new_pl;
  logic           s2_adv;
  logic           can_accept;
  logic           take;
  logic [PRW-1:0] core_z;

  // First valid requester searching upward from last_grant+1, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(last_grant) + 32'd1 + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
      end
    end
  end

  always_comb begin
    s2_adv     = !res_valid || res_ready;
    can_accept = !s1_valid || s2_adv;
    take       = rst_n && found && can_accept;
    req_ready  = take ? (NREQ'(1) << gidx) : '0;

    new_pl    = '0;
    new_pl.x  = req_x[gidx*OPW +: OPW];
    new_pl.y  = req_y[gidx*OPW +: OPW];
    new_pl.id = ID_MAXW'(gidx);
`ifdef APPROX_MUL_EXACT_EN
    new_pl.exact = req_exact[gidx];
`endif
  end

  approx_mul8_core u_core (
    .x     (s1_q.x),
    .y     (s1_q.y),
`ifdef APPROX_MUL_EXACT_EN
    .exact (s1_q.exact),
`else
    .exact (1'b0),
`endif
    .z     (core_z)
  );

  // S1 refills in the same cycle it drains into S2, so back-to-back requests stream at full rate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      res_valid  <= 1'b0;
      res_z      <= '0;
      res_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      if (s2_adv) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_z  <= core_z;
          res_id <= IDW'(s1_q.id);
        end
      end
      if (take) begin
        s1_valid   <= 1'b1;
        s1_q       <= new_pl;
        last_grant <= gidx;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Self-checking bench: directed and random traffic against a cycle-level reference model.
module tb_approx_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*8-1:0]   req_x;
  logic [NREQ*8-1:0]   req_y;
`ifdef APPROX_MUL_EXACT_EN
  logic [NREQ-1:0]     req_exact;
`endif
  logic                res_valid;
  logic                res_ready;
  logic [15:0]         res_z;
  logic [IDW-1:0]      res_id;

  approx_mul_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
`ifdef APPROX_MUL_EXACT_EN
    .req_exact (req_exact),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // operands per requester
  int mx [NREQ];
  int my [NREQ];
  bit mex[NREQ];

  // reference model: round-robin pointer and two pipeline slots
  int m_lg;
  bit m_s1v, m_s2v;
  int m_s1z, m_s1id, m_s2z, m_s2id;
  bit last_acc;
  int last_win;

  function automatic int bitof(input int v, input int k);
    return (v >> k) & 1;
  endfunction

  function automatic int ref_product(input int x, input int y, input bit ex);
    int p1, p2, p3, c;
    if (ex) return x * y;
    p1 = bitof(x, 1) ? y : 0;
    p2 = bitof(x, 2) ? y : 0;
    p3 = bitof(x, 3) ? y : 0;
    c = 256  * (bitof(p1, 7) + (bitof(p2, 5) | bitof(p3, 4)))
      + 512  * ((bitof(p2, 6) | bitof(p3, 5)) + (bitof(p2, 7) ^ bitof(p3, 6)))
      + 1024 * ((bitof(p2, 7) & bitof(p3, 6)) + bitof(p3, 7));
    return ((y * (x / 16)) * 16 + c) % 65536;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*8 +: 8] = 8'(mx[i]);
      req_y[i*8 +: 8] = 8'(my[i]);
`ifdef APPROX_MUL_EXACT_EN
      req_exact[i] = mex[i];
`endif
    end
  endtask

  // One clock cycle: predict, check away from the edge, then advance the model at the edge.
  task automatic step();
    int win;
    bit can, acc;
    logic [NREQ-1:0] exp_ready;
    pack();
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_lg + k) % NREQ;
      if (win < 0 && req_valid[i]) win = i;
    end
    can = !m_s1v || !m_s2v || res_ready;
    acc = rst_n && (win >= 0) && can;
    exp_ready = acc ? NREQ'(1 << win) : '0;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(m_s2v));
    if (m_s2v) begin
      check("res_z", 32'(res_z), 32'(m_s2z));
      check("res_id", 32'(res_id), 32'(m_s2id));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_s1v = 0; m_s2v = 0; m_lg = NREQ - 1;
      m_s2z = 0; m_s2id = 0;
    end else begin
      if (!m_s2v || res_ready) begin
        m_s2v = m_s1v;
        if (m_s1v) begin m_s2z = m_s1z; m_s2id = m_s1id; end
        m_s1v = 0;
      end
      if (acc) begin
        m_s1v  = 1;
        m_s1id = win;
        m_s1z  = ref_product(mx[win], my[win], mex[win]);
        m_lg   = win;
      end
    end
    last_acc = acc;
    last_win = win;
    @(negedge clk);
  endtask

  // Random traffic; a valid request is held with its operands until the model says it was taken.
  task automatic run(input int n, input int vprob, input int rprob);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || (last_acc && last_win == i)) begin
          req_valid[i] = ($urandom_range(99) < vprob);
          mx[i] = $urandom_range(255);
          my[i] = $urandom_range(255);
`ifdef APPROX_MUL_EXACT_EN
          mex[i] = $urandom_range(1);
`else
          mex[i] = 0;
`endif
        end
      end
      res_ready = ($urandom_range(99) < rprob);
      last_acc = 0;
      step();
    end
  endtask

  task automatic single(input int id, input int x, input int y, input bit ex, input int expz);
    req_valid = '0;
    req_valid[id] = 1'b1;
    mx[id] = x; my[id] = y; mex[id] = ex;
    step();
    req_valid = '0;
    step();
    #1;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_z", 32'(res_z), 32'(expz));
    check("single_id", 32'(res_id), 32'(id));
    step();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin mx[i] = 0; my[i] = 0; mex[i] = 0; end
    pack();
    m_lg = NREQ - 1; m_s1v = 0; m_s2v = 0; m_s2z = 0; m_s2id = 0;
    last_acc = 0; last_win = -1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    step();
    step();
    #1;
    check("rst_z", 32'(res_z), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    single(2, 8'h10, 8'h03, 0, 16'h0030);
    single(0, 8'hFF, 8'hFF, 0, 16'hFB10);
    single(1, 8'h0F, 8'h80, 0, 16'h0700);
`ifdef APPROX_MUL_EXACT_EN
    single(3, 8'hFF, 8'hFF, 1, 16'hFE01);
    single(1, 8'h0F, 8'h80, 1, 16'h0780);
`endif

    // all requesters continuously valid, full throughput
    req_valid = '1;
    last_acc = 0;
    run(16, 100, 100);
    // downstream stall for five cycles, then release
    run(5, 100, 0);
    run(10, 100, 100);

    run(300, 60, 70);
    run(100, 100, 30);

    // fill both stages, then a one-cycle reset
    run(4, 100, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = '1;
    #1;
    check("post_rst_valid", 32'(res_valid), 32'd0);
    check("post_rst_grant", 32'(req_ready), 32'd1);
    step();
    run(20, 100, 100);

    req_valid = '0;
    run(4, 0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/approx_mul_arbiter.md
APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL provide localparam IDW = $clog2(NREQ), the result tag width.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester operand valid.
REQ-006 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_x  in  NREQ*8  packed multiplicands; requester i occupies bits [8i+7:8i].
REQ-008 req_y  in  NREQ*8  packed multipliers, same packing as req_x.
REQ-009 res_valid  out  1  result valid.
REQ-010 res_ready  in  1  downstream accept.
REQ-011 res_z  out  16  product.
REQ-012 res_id  out  IDW  index of the requester that issued the result.

Function
REQ-013 Handshake: a transfer occurs when valid and ready are both high in the same cycle; a held valid SHALL NOT be withdrawn by the block's arbitration.
REQ-014 Arbitration SHALL be round-robin; priority starts at last_grant+1 mod NREQ; last_grant updates only on an accepted request.
REQ-015 req_ready[i] SHALL be high only for the winning requester, and only when stage S1 is empty or advancing this cycle.
REQ-016 Pipeline SHALL have two stages: S1 registers operands and id; S2 registers res_z and res_id.
REQ-017 Latency SHALL be 2 cycles from request acceptance to res_valid when res_ready is held high.
REQ-018 Throughput SHALL be one result per cycle under continuous requests with res_ready high.
REQ-019 While res_valid=1 and res_ready=0, res_z and res_id SHALL hold stable; S1 SHALL hold if occupied, and no new request is accepted while S1 is full and blocked.
REQ-020 Simultaneous S2 drain and S1 advance in the same cycle SHALL lose no result.
REQ-021 Approximate product: z = ((y*x[7:4]) << 4) + C mod 2^16, with p_k = y & {8{x[k]}} and C = 256*(p1[7] + (p2[5]|p3[4])) + 512*((p2[6]|p3[5]) + (p2[7]^p3[6])) + 1024*((p2[7]&p3[6]) + p3[7]).
REQ-022 With no req_valid asserted, req_ready SHALL be all zero and last_grant SHALL be unchanged.
REQ-023 Results SHALL leave in acceptance order.

Reset
REQ-024 rst_n=0 on a clock edge SHALL clear both stage valids, and res_valid, res_z and res_id SHALL read 0.
REQ-025 Reset SHALL set last_grant to NREQ-1, so requester 0 has first priority.
REQ-026 req_ready SHALL be 0 during reset.
REQ-027 Reset during operation SHALL discard in-flight results with no output pulse afterwards.

Configuration
REQ-028 Macro APPROX_MUL_EXACT_EN, when defined, SHALL add input req_exact (NREQ bits, one per requester), carried through S1 with the operands.
REQ-029 With APPROX_MUL_EXACT_EN defined, a request accepted with req_exact[i]=1 SHALL produce the exact product x*y; otherwise the REQ-021 product.
REQ-030 Without APPROX_MUL_EXACT_EN, the req_exact port SHALL be absent and every result SHALL be the REQ-021 product.

Structure
REQ-031 Shared package approx_mul_pkg SHALL hold: operand width 8, product width 16, the NREQ default, and the S1 payload struct (x, y, id, and exact when enabled).
REQ-032 Product logic SHALL be one combinational sub-module, approx_mul8_core (x, y, exact -> z), instantiated once between S1 and S2.
REQ-033 Arbiter and pipeline control SHALL reside in approx_mul_arbiter.

Verification
REQ-034 Single request: x=0x10, y=0x03 on requester 2 -> res_z=0x0030, res_id=2, 2 cycles later.
REQ-035 Worst case: x=0xFF, y=0xFF -> res_z=0xFB10 (64272); with APPROX_MUL_EXACT_EN and exact=1 -> 0xFE01.
REQ-036 Low nibble only: x=0x0F, y=0x80 -> res_z=0x0700 (exact 0x0780).
REQ-037 All four requesters held valid, res_ready=1 -> grants 0,1,2,3,0,... one per cycle, res_id in the same order.
REQ-038 res_ready low for 5 cycles with continuous requests -> res_z/res_id stable, no loss or duplication, order preserved after release.
REQ-039 rst_n low 1 cycle with both stages full -> res_valid=0 next cycle, first grant goes to requester 0.
